// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: state encoding and default parameters shared by the layer read scheduler
package cnn_sched_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT, READY, ERROR} state_t;
  localparam int DEF_NUM_LAYERS = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_RD_LAT = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant with a pointer that favours A after reset
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic fav_b;
  // contention goes to whoever was not granted last; a lone request wins outright
  always_comb begin
    gnt_a = en && req_a && (!req_b || !fav_b);
    gnt_b = en && req_b && (!req_a || fav_b);
  end
  // pointer only moves when a grant is actually issued
  always_ff @(posedge clk)
    if (reset) fav_b <= 1'b0;
    else if (gnt_a || gnt_b) fav_b <= gnt_a;
endmodule

// File: rtl/layer_read_scheduler.sv
// layer_read_scheduler: sequences CNN layer stages, then arbitrates reads of the final layer's buffer
module layer_read_scheduler import cnn_sched_pkg::*; #(
  parameter int NUM_LAYERS     = DEF_NUM_LAYERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int RD_LAT         = DEF_RD_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  busy,
  output logic                  ready,
  output logic                  err,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  req_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic                  req_b,
  input  logic [ADDR_W-1:0]     addr_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid_a,
  output logic                  rvalid_b
);
  localparam int IW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RD_LAT-1:0] pipe_a, pipe_b;
  logic done_cur, last, timed_out, rd_en;
  assign done_cur = layer_done[idx];
  assign last = idx == IW'(NUM_LAYERS - 1);
  // the error lands on the edge where the counter would reach TIMEOUT_CYCLES-1,
  // so err is visible exactly TIMEOUT_CYCLES cycles after the start pulse
  assign timed_out = 32'(cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES - 1);
  assign rd_en = state == READY;
  // next-state, layer index and timeout counter
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    case (state)
      IDLE, READY, ERROR: if (run) begin
        state_n = START;
        idx_n = '0;
      end
      START: begin
        state_n = WAIT;
        cnt_n = '0;
      end
      WAIT: if (done_cur) begin
        state_n = last ? READY : START;
        idx_n = last ? idx : idx + 1'b1;
      end else if (timed_out) state_n = ERROR;
      else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // status outputs decode directly from the state
  always_comb begin
    busy = state == START || state == WAIT;
    ready = state == READY;
    err = state == ERROR;
    layer_start = state == START ? NUM_LAYERS'(1) << idx : '0;
  end
  // sequencer state register
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
    end
  rr_arbiter2 u_arb (
    .clk  (clk),
    .reset(reset),
    .en   (rd_en),
    .req_a(req_a),
    .req_b(req_b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b)
  );
  // read pipeline: per-requester valid tags follow the address through the RAM latency
  always_ff @(posedge clk)
    if (reset) begin
      rd_addr <= '0;
      pipe_a <= '0;
      pipe_b <= '0;
      rdata <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      if (gnt_a || gnt_b) rd_addr <= gnt_a ? addr_a : addr_b;
      pipe_a <= (pipe_a << 1) | RD_LAT'(gnt_a);
      pipe_b <= (pipe_b << 1) | RD_LAT'(gnt_b);
      if (pipe_a[RD_LAT-1] || pipe_b[RD_LAT-1]) rdata <= rd_data;
      rvalid_a <= pipe_a[RD_LAT-1];
      rvalid_b <= pipe_b[RD_LAT-1];
    end
endmodule

// File: tb/tb_layer_read_scheduler.sv
// tb_layer_read_scheduler: layer sequencing, timeout, arbitration and reset checks
module tb_layer_read_scheduler;
  localparam int NL = 4, TO = 16, AW = 32, DW = 4;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic busy, ready, err, gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [NL-1:0] layer_start, layer_done = '0;
  logic req_a = 1'b0, req_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0, rd_addr;
  logic [DW-1:0] rd_data, rdata;
  int checks = 0, fails = 0, cyc = 0;
  int auto_done = 0, skip = -1, dn_timer = 0, dn_idx = 0;
  typedef struct packed { logic ra, rb, ga, gb, va, vb; logic [DW-1:0] d; } vec_t;
  typedef struct { int due; logic b; logic [DW-1:0] d; } ret_t;
  vec_t tbl[11];
  ret_t exp_q[$];

  layer_read_scheduler #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(TO), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .run(run), .busy(busy), .ready(ready), .err(err),
    .layer_start(layer_start), .layer_done(layer_done),
    .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rd_addr(rd_addr), .rd_data(rd_data),
    .rdata(rdata), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_of(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 4) ^ AW'(5));
  endfunction
  // final-layer buffer with single-cycle read latency from the registered address
  assign rd_data = mem_of(rd_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // advance one clock; auto responder pulses layer_done 10 cycles after each start
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    run = 1'b0;
    layer_done = '0;
    if (dn_timer > 0) begin
      dn_timer--;
      if (dn_timer == 0 && dn_idx != skip) layer_done[dn_idx] = 1'b1;
    end
    if (auto_done != 0 && layer_start != 0) begin
      for (int i = 0; i < NL; i++) if (layer_start[i]) dn_idx = i;
      dn_timer = 10;
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_start"}, layer_start, 0);
    check({tag, "_gnt"}, {gnt_a, gnt_b}, 0);
    check({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic run_to_ready();
    int n;
    n = 0;
    auto_done = 1;
    skip = -1;
    dn_timer = 0;
    tick();
    run = 1'b1;
    @(negedge clk);
    while (!ready && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("seq_ready", ready, 1);
  endtask

  initial begin
    int n_starts, found, c0;
    logic m_last_b, ea, eb, eva, evb, ga_prev, gb_prev;
    logic [DW-1:0] da, db;
    da = mem_of(32'h10);
    db = mem_of(32'h20);
    tbl[0]  = {6'b111000, 4'h0};
    tbl[1]  = {6'b110100, 4'h0};
    tbl[2]  = {6'b111010, da};
    tbl[3]  = {6'b110101, db};
    tbl[4]  = {6'b000010, da};
    tbl[5]  = {6'b101001, db};
    tbl[6]  = {6'b010100, 4'h0};
    tbl[7]  = {6'b111010, da};
    tbl[8]  = {6'b000001, db};
    tbl[9]  = {6'b000010, da};
    tbl[10] = {6'b000000, 4'h0};

    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // full sequence, every layer done 10 cycles after its start
    auto_done = 1;
    tick();
    run = 1'b1;
    c0 = cyc;
    @(negedge clk);
    n_starts = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      @(negedge clk);
      if (layer_start != 0) begin
        check("start_onehot", $countones(layer_start), 1);
        check("start_order", layer_start, NL'(1) << n_starts);
        check("start_time", cyc - c0, 1 + 11 * n_starts);
        n_starts++;
      end
      if (k == 44) check("busy_before_ready", {busy, ready}, 2'b10);
      if (k == 45) check("ready_after_done3", {busy, ready}, 2'b01);
    end
    check("start_count", n_starts, 4);

    // arbitration vectors in READY
    addr_a = 32'h10;
    addr_b = 32'h20;
    for (int i = 0; i < 11; i++) begin
      tick();
      req_a = tbl[i].ra;
      req_b = tbl[i].rb;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", i), {gnt_a, gnt_b}, {tbl[i].ga, tbl[i].gb});
      check($sformatf("tbl%0d_rvalid", i), {rvalid_a, rvalid_b}, {tbl[i].va, tbl[i].vb});
      if (tbl[i].va || tbl[i].vb) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].d);
    end

    // random requests against a queue-based reference
    m_last_b = 1'b0;
    ga_prev = 1'b0;
    gb_prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (ga_prev) req_a = 1'b0;
      if (gb_prev) req_b = 1'b0;
      if (!req_a && i < 295 && $urandom_range(0, 2) != 0) begin req_a = 1'b1; addr_a = $urandom_range(0, 255); end
      if (!req_b && i < 295 && $urandom_range(0, 2) != 0) begin req_b = 1'b1; addr_b = $urandom_range(0, 255); end
      @(negedge clk);
      ea = req_a && (!req_b || m_last_b);
      eb = req_b && (!req_a || !m_last_b);
      check("rnd_gnt", {gnt_a, gnt_b}, {ea, eb});
      if (ea || eb) begin
        exp_q.push_back('{cyc + 2, eb, mem_of(eb ? addr_b : addr_a)});
        m_last_b = eb;
      end
      ga_prev = ea;
      gb_prev = eb;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      eva = exp_q.size() > 0 && exp_q[0].due == cyc && !exp_q[0].b;
      evb = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].b;
      check("rnd_rvalid", {rvalid_a, rvalid_b}, {eva, evb});
      if (eva || evb) begin
        check("rnd_rdata", rdata, exp_q[0].d);
        void'(exp_q.pop_front());
      end
    end
    check("rnd_drained", exp_q.size(), 0);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();

    // run while a read is granted: read still returns, requests wait out the sequence
    auto_done = 1;
    skip = -1;
    dn_timer = 0;
    tick();
    req_a = 1'b1;
    addr_a = 32'h33;
    run = 1'b1;
    @(negedge clk);
    check("leave_ready_gnt", gnt_a, 1);
    tick();
    addr_a = 32'h44;
    @(negedge clk);
    check("start_nogrant", {gnt_a, busy}, 2'b01);
    tick();
    @(negedge clk);
    check("inflight_rvalid", rvalid_a, 1);
    check("inflight_rdata", rdata, mem_of(32'h33));
    found = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      @(negedge clk);
      if (!ready) check("wait_nogrant", gnt_a, 0);
      else begin
        check("first_ready_grant", gnt_a, 1);
        found = 1;
        break;
      end
    end
    check("reached_ready", found, 1);
    tick();
    req_a = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("held_req_rvalid", rvalid_a, 1);
    check("held_req_rdata", rdata, mem_of(32'h44));

    // timeout: layer 1 never reports done
    auto_done = 1;
    skip = 1;
    dn_timer = 0;
    tick();
    run = 1'b1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      @(negedge clk);
      if (layer_start[1]) begin found = 1; break; end
    end
    check("l1_started", found, 1);
    for (int k = 1; k <= TO; k++) begin
      tick();
      @(negedge clk);
      if (k == TO - 1) check("pre_timeout", {busy, err}, 2'b10);
      if (k == TO) check("timeout_err", {busy, ready, err}, 3'b001);
    end
    tick();
    run = 1'b1;
    @(negedge clk);
    check("err_holds_until_edge", err, 1);
    tick();
    @(negedge clk);
    check("rerun_err_clear", err, 0);
    check("rerun_start0", layer_start, 1);

    // stray done from another layer is ignored; reset mid-wait clears everything
    auto_done = 0;
    dn_timer = 0;
    tick();
    layer_done = 4'b0110;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("stray_ignored", {busy, layer_start != 0}, 2'b10);
    tick();
    layer_done = 4'b1010;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst_wait");

    // reset with a read in flight discards it and restores the A-first pointer
    run_to_ready();
    tick();
    req_a = 1'b1;
    addr_a = 32'h5a;
    @(negedge clk);
    check("pre_rst_gnt", gnt_a, 1);
    tick();
    req_a = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_zero("rst_read");
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("no_late_rvalid", {rvalid_a, rvalid_b}, 0);
    end
    run_to_ready();
    tick();
    req_a = 1'b1;
    req_b = 1'b1;
    @(negedge clk);
    check("ptr_reset_favours_a", {gnt_a, gnt_b}, 2'b10);
    tick();
    req_a = 1'b0;
    req_b = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
